// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package wide_add_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wide_add_state_t;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/fulladder32.sv
// 32-bit ripple-style full adder with carry in and carry out (purely combinational).
module fulladder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    assign sum     = total_s[31:0];
    assign cout    = total_s[32];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract: one 32-bit word per clock through a single
// fulladder32, least-significant word first, carry chained through a register.
// Subtraction is a + ~b + 1, so the inverted operand is stored at accept time
// and the initial carry is the sub flag.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    sub_i,
    input  logic [WORD_W*WORDS-1:0] a_i,
    input  logic [WORD_W*WORDS-1:0] b_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [WORD_W*WORDS-1:0] sum_o,
    output logic                    carry_o,
    output logic                    ovf_o
);

    localparam int W     = WORD_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    wide_add_state_t   state_r, state_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic              carry_r, carry_s;
    logic [W-1:0]      a_r, a_s;
    logic [W-1:0]      b_r, b_s;
    logic [W-1:0]      sum_r, sum_s;
    logic              cout_r, cout_s;
    logic              ovf_r, ovf_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic              req_ready_r, req_ready_s;

    logic [WORD_W-1:0] word_a_s;
    logic [WORD_W-1:0] word_b_s;
    logic [WORD_W-1:0] add_sum_s;
    logic              add_cout_s;

    assign word_a_s = a_r[idx_r*WORD_W +: WORD_W];
    assign word_b_s = b_r[idx_r*WORD_W +: WORD_W];

    fulladder32 u_adder (
        .a    (word_a_s),
        .b    (word_b_s),
        .cin  (carry_r),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        carry_s     = carry_r;
        a_s         = a_r;
        b_s         = b_r;
        sum_s       = sum_r;
        cout_s      = cout_r;
        ovf_s       = ovf_r;
        rsp_valid_s = rsp_valid_r;
        req_ready_s = req_ready_r;

        case (state_r)
            IDLE: begin
                if (req_valid_i) begin
                    a_s         = a_i;
                    b_s         = sub_i ? ~b_i : b_i;
                    carry_s     = sub_i;
                    idx_s       = IDX_ZERO;
                    state_s     = RUN;
                    req_ready_s = 1'b0;
                end else begin
                    req_ready_s = 1'b1;
                end
                rsp_valid_s = 1'b0;
            end
            RUN: begin
                sum_s[idx_r*WORD_W +: WORD_W] = add_sum_s;
                carry_s                       = add_cout_s;
                req_ready_s                   = 1'b0;
                if (idx_r == LAST_IDX) begin
                    // Final word: flags come from the top word's adder result.
                    cout_s      = add_cout_s;
                    ovf_s       = signed_ovf(a_r[W-1], b_r[W-1], add_sum_s[WORD_W-1]);
                    state_s     = DONE;
                    rsp_valid_s = 1'b1;
                end else begin
                    idx_s       = idx_r + IDX_ONE;
                    rsp_valid_s = 1'b0;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_s     = IDLE;
                    rsp_valid_s = 1'b0;
                    req_ready_s = 1'b1;
                end else begin
                    rsp_valid_s = 1'b1;
                    req_ready_s = 1'b0;
                end
            end
            default: begin
                state_s     = IDLE;
                rsp_valid_s = 1'b0;
                req_ready_s = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers; reset discards any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            idx_r       <= IDX_ZERO;
            carry_r     <= 1'b0;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            sum_r       <= {W{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            carry_r     <= carry_s;
            a_r         <= a_s;
            b_r         <= b_s;
            sum_r       <= sum_s;
            cout_r      <= cout_s;
            ovf_r       <= ovf_s;
            rsp_valid_r <= rsp_valid_s;
            req_ready_r <= req_ready_s;
        end
    end

    assign req_ready_o = req_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign sum_o       = sum_r;
    assign carry_o     = cout_r;
    assign ovf_o       = ovf_r;

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
Multi-precision add/subtract sequencer. It computes a WORDS×32-bit add or subtract by time-multiplexing a single fulladder32 instance, one 32-bit word per clock, least-significant word first, with the carry chained through a register. It sits beside the ALU as the datapath for wide (64/128-bit) arithmetic. Valid/ready handshakes are used on both the request side and the response side.

Parameters:
WORDS, 4, number of 32-bit words per operand (WORDS ≥ 1); operand width W = 32*WORDS.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready (high only in IDLE)
sub_i  in  1  0 = a+b, 1 = a−b; sampled on request accept
a_i  in  W  operand A, sampled on request accept
b_i  in  W  operand B, sampled on request accept
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  result consumed
sum_o  out  W  result word vector
carry_o  out  1  carry out of MSB (for subtract: 1 = no borrow)
ovf_o  out  1  two's-complement signed overflow

Behaviour:
- Reset (async assert, any state): state=IDLE, word index=0, carry reg=0, operand regs=0, sum_o=0, carry_o=0, ovf_o=0, rsp_valid_o=0, req_ready_o=1. Any operation in flight is discarded with no partial response.
- States:
  - IDLE: req_ready_o=1. On req_valid_i at a rising edge (accept edge E0): latch a_i; latch b_i, or ~b_i if sub_i; set carry reg = sub_i; set idx=0; go to RUN.
  - RUN: adder inputs are A[idx], B'[idx] and the carry reg. At each edge, write the sum into sum word idx, write carry_o of the adder into the carry reg, and increment idx. At the edge where idx == WORDS−1, also:
    - set carry_o = adder carry out;
    - set ovf_o = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the inverted B for subtract;
    - go to DONE and set rsp_valid_o=1.
  - DONE: rsp_valid_o=1. sum_o, carry_o and ovf_o are held stable. On rsp_ready_i, go to IDLE and clear rsp_valid_o. req_ready_o=0, so no new request is accepted in the same cycle.
- Latency: rsp_valid_o becomes visible exactly WORDS cycles after the accept edge (WORDS=1 gives 1 cycle). Minimum issue interval is WORDS+2 cycles.
- req_valid_i is ignored outside IDLE. sub_i, a_i and b_i may change freely after accept.
- Outputs are registered.
  - sum_o words not yet written during RUN keep their previous values; they are don't-care until rsp_valid_o.
  - carry_o and ovf_o update only at the final RUN edge.
- Index counter width is max(1, $clog2(WORDS)). The index never exceeds WORDS−1; no wrap-around hazard.
- rst_i asserted during DONE with rsp_ready_i low: the response is lost, which is acceptable; outputs are zero immediately.

Decomposition:
- Package wide_add_pkg holds:
  - WORD_W = 32;
  - typedef enum logic [1:0] {IDLE, RUN, DONE} wide_add_state_t.
- One sub-module: the existing fulladder32, instantiated once. A and B' word selection uses indexed part-select [idx*WORD_W +: WORD_W].
- No other sub-modules.

Test Plan:
1. WORDS=4, add, a=128'hFFFF…FFFF, b=1 -> sum_o=0, carry_o=1, ovf_o=0, rsp_valid_o high exactly 4 cycles after accept.
2. Add across a word boundary: a=128'h0…0_00000001_FFFFFFFF, b=1 -> sum_o=128'h0…0_00000002_00000000, carry_o=0.
3. Subtract: a=0, b=1 -> sum_o=all ones, carry_o=0 (borrow), ovf_o=0. Subtract a=5, b=3 -> sum_o=2, carry_o=1.
4. Signed overflow: add a=128'h7FFF…FFFF, b=1 -> sum_o=128'h8000…0000, ovf_o=1, carry_o=0. Subtract a=128'h8000…0, b=1 -> ovf_o=1.
5. Backpressure: hold rsp_ready_i=0 for 5 cycles in DONE while toggling req_valid_i and the operands -> sum_o, carry_o and ovf_o stay stable, req_ready_o=0, nothing accepted. Release rsp_ready_i -> IDLE next cycle, and a new request is accepted on the following edge.
6. Assert rst_i asynchronously mid-RUN at idx=2 -> all outputs 0 without waiting for a clock edge, req_ready_o=1 while in reset. After release, a fresh add 3+4 returns sum_o=7 with correct latency. Repeat with WORDS=1: 32'hFFFFFFFF+1 -> sum_o=0, carry_o=1, 1-cycle latency.
